// File: rtl/demux_checker.sv
// ---------------------------------------------------------------------------
// demux_checker
//
// Purpose:
//   Cycle-by-cycle equivalence checker between a behavioural demux and its
//   structural (synthesized) counterpart. Every rising edge it compares the
//   data outputs and the push/valid outputs of both implementations. It
//   registers the result together with sticky and cumulative error
//   information.
//
// Optional feature:
//   DEMUX_CHECKER_XCHECK_EN  - when defined, any X/Z bit on a compared input
//                              is a mismatch in that input's category, even
//                              when both sides carry the same X/Z pattern.
//                              When undefined, the compares are plain bitwise
//                              equality and the block is fully synthesizable.
//
// Ports:
//   clk               in   rising-edge clock for all state
//   reset_L           in   asynchronous active-low reset
//   salida_demux0_c   in   [DATA_WIDTH]  data out, behavioural demux
//   salida_demux0_e   in   [DATA_WIDTH]  data out, structural demux
//   salida_demux1_c   in   push out, behavioural demux
//   salida_demux1_e   in   push out, structural demux
//   demux_checks_out  out  1 = previous-cycle comparison passed
//   check_valid       out  1 = at least one comparison registered since reset
//   error_sticky      out  1 = any mismatch since reset
//   fail_vector       out  [2] {push_mismatch, data_mismatch} of latest cycle
//   mismatch_count    out  [COUNT_WIDTH] mismatching cycles, saturating
//   first_fail_cycle  out  [CYCLE_WIDTH] cycle index of first mismatch
//                          (all-ones until a mismatch occurs)
// ---------------------------------------------------------------------------
module demux_checker #(
    parameter int DATA_WIDTH  = 5,
    parameter int COUNT_WIDTH = 8,
    parameter int CYCLE_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic [DATA_WIDTH-1:0]  salida_demux0_c,
    input  logic [DATA_WIDTH-1:0]  salida_demux0_e,
    input  logic                   salida_demux1_c,
    input  logic                   salida_demux1_e,
    output logic                   demux_checks_out,
    output logic                   check_valid,
    output logic                   error_sticky,
    output logic [1:0]             fail_vector,
    output logic [COUNT_WIDTH-1:0] mismatch_count,
    output logic [CYCLE_WIDTH-1:0] first_fail_cycle
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};
    localparam logic [CYCLE_WIDTH-1:0] CYCLE_MAX = {CYCLE_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CYCLE_WIDTH-1:0] CYCLE_ONE = {{(CYCLE_WIDTH-1){1'b0}}, 1'b1};

    // Data-path inequality. With the X-check build, unknown bits on either
    // side force a mismatch so that identical X patterns cannot hide a bug.
    function automatic logic data_differs(input logic [DATA_WIDTH-1:0] a,
                                          input logic [DATA_WIDTH-1:0] b);
`ifdef DEMUX_CHECKER_XCHECK_EN
        return ($isunknown(a) || $isunknown(b) || (a !== b));
`else
        return (a != b);
`endif
    endfunction

    // Push-path inequality, same X policy as the data path.
    function automatic logic push_differs(input logic a, input logic b);
`ifdef DEMUX_CHECKER_XCHECK_EN
        return ($isunknown(a) || $isunknown(b) || (a !== b));
`else
        return (a != b);
`endif
    endfunction

    logic                   data_mis_s;
    logic                   push_mis_s;
    logic                   any_mis_s;

    logic                   checks_ok_r;
    logic                   check_valid_r;
    logic                   error_sticky_r;
    logic [1:0]             fail_vector_r;
    logic [COUNT_WIDTH-1:0] mismatch_count_r;
    logic [CYCLE_WIDTH-1:0] first_fail_cycle_r;
    logic [CYCLE_WIDTH-1:0] cycle_cnt_r;

    // Compare both demux implementations every cycle, regardless of push.
    always_comb begin
        data_mis_s = data_differs(salida_demux0_c, salida_demux0_e);
        push_mis_s = push_differs(salida_demux1_c, salida_demux1_e);
        any_mis_s  = data_mis_s | push_mis_s;
    end

    // Register compare results and maintain the error history.
    // cycle_cnt_r holds the index of the edge currently being registered:
    // 0 on the first edge after reset release.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            checks_ok_r        <= 1'b0;
            check_valid_r      <= 1'b0;
            error_sticky_r     <= 1'b0;
            fail_vector_r      <= 2'b00;
            mismatch_count_r   <= {COUNT_WIDTH{1'b0}};
            first_fail_cycle_r <= CYCLE_MAX;
            cycle_cnt_r        <= {CYCLE_WIDTH{1'b0}};
        end else begin
            checks_ok_r   <= ~any_mis_s;
            check_valid_r <= 1'b1;
            fail_vector_r <= {push_mis_s, data_mis_s};

            if (any_mis_s) begin
                error_sticky_r <= 1'b1;
                // A cycle with both mismatch kinds still counts once.
                if (mismatch_count_r != COUNT_MAX) begin
                    mismatch_count_r <= mismatch_count_r + COUNT_ONE;
                end else begin
                    mismatch_count_r <= mismatch_count_r;
                end
                // Only the very first mismatch since reset is recorded.
                if (!error_sticky_r) begin
                    first_fail_cycle_r <= cycle_cnt_r;
                end else begin
                    first_fail_cycle_r <= first_fail_cycle_r;
                end
            end else begin
                error_sticky_r     <= error_sticky_r;
                mismatch_count_r   <= mismatch_count_r;
                first_fail_cycle_r <= first_fail_cycle_r;
            end

            if (cycle_cnt_r != CYCLE_MAX) begin
                cycle_cnt_r <= cycle_cnt_r + CYCLE_ONE;
            end else begin
                cycle_cnt_r <= cycle_cnt_r;
            end
        end
    end

    assign demux_checks_out = checks_ok_r;
    assign check_valid      = check_valid_r;
    assign error_sticky     = error_sticky_r;
    assign fail_vector      = fail_vector_r;
    assign mismatch_count   = mismatch_count_r;
    assign first_fail_cycle = first_fail_cycle_r;

endmodule

// File: tb/tb_demux_checker.sv
// ---------------------------------------------------------------------------
// tb_demux_checker
//
// Self-checking bench for demux_checker. A behavioural reference model
// (plain integers) tracks the expected outputs edge by edge. Directed steps
// are followed by randomized traffic, counter saturation and a mid-stream
// asynchronous reset. Inputs change on the falling edge, and outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_demux_checker;

    localparam int DW = 5;
    localparam int CW = 8;
    localparam int YW = 16;

    logic          clk;
    logic          reset_L;
    logic [DW-1:0] dc;
    logic [DW-1:0] de;
    logic          pc;
    logic          pe;
    logic          ok_o;
    logic          valid_o;
    logic          sticky_o;
    logic [1:0]    fv_o;
    logic [CW-1:0] cnt_o;
    logic [YW-1:0] first_o;

    // Reference model state
    int m_ok, m_valid, m_sticky, m_fv, m_cnt, m_first, m_cyc;

    int n_checks;
    int n_fail;

    demux_checker #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .CYCLE_WIDTH(YW)) dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .salida_demux0_c  (dc),
        .salida_demux0_e  (de),
        .salida_demux1_c  (pc),
        .salida_demux1_e  (pe),
        .demux_checks_out (ok_o),
        .check_valid      (valid_o),
        .error_sticky     (sticky_o),
        .fail_vector      (fv_o),
        .mismatch_count   (cnt_o),
        .first_fail_cycle (first_o)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ok = 0; m_valid = 0; m_sticky = 0; m_fv = 0;
        m_cnt = 0; m_first = (1 << YW) - 1; m_cyc = 0;
    endtask

    // Model one rising edge from the spec rules, using 4-state inequality
    // so that any unknown bit counts as a mismatch in its category.
    task automatic model_edge();
        int dm, pm;
        dm = ($isunknown(dc) || $isunknown(de) || (dc !== de)) ? 1 : 0;
        pm = ($isunknown(pc) || $isunknown(pe) || (pc !== pe)) ? 1 : 0;
        m_fv    = pm * 2 + dm;
        m_ok    = (dm + pm == 0) ? 1 : 0;
        m_valid = 1;
        if (dm + pm != 0) begin
            if (m_sticky == 0) m_first = m_cyc;
            m_sticky = 1;
            if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
        end
        if (m_cyc < (1 << YW) - 1) m_cyc = m_cyc + 1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".checks_out"}, 32'(ok_o),     32'(m_ok));
        chk({tag, ".check_valid"}, 32'(valid_o), 32'(m_valid));
        chk({tag, ".sticky"},     32'(sticky_o), 32'(m_sticky));
        chk({tag, ".fail_vec"},   32'(fv_o),     32'(m_fv));
        chk({tag, ".count"},      32'(cnt_o),    32'(m_cnt));
        chk({tag, ".first_fail"}, 32'(first_o),  32'(m_first));
    endtask

    // Apply inputs (called just after a falling edge), run one edge,
    // then sample on the next falling edge.
    task automatic step(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic p, input logic q);
        dc = a; de = b; pc = p; pe = q;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_L  = 1'b1;
        dc = 5'h00; de = 5'h00; pc = 1'b0; pe = 1'b0;
        model_reset();

        // Power-on reset: outputs must take reset values with no clock edge.
        #2 reset_L = 1'b0;
        #1 check_all("reset");
        @(negedge clk);
        @(negedge clk);
        reset_L = 1'b1;

        // Matching traffic, three cycles.
        for (int i = 0; i < 3; i++) step(5'h0F, 5'h0F, 1'b1, 1'b1);
        check_all("match3");
        chk("match3.ok_const", 32'(ok_o), 32'd1);

        // Single data mismatch at cycle index 3.
        step(5'h03, 5'h02, 1'b1, 1'b1);
        check_all("data_mis");
        chk("data_mis.fv_const", 32'(fv_o), 32'd1);
        chk("data_mis.first_const", 32'(first_o), 32'd3);

        step(5'h07, 5'h07, 1'b0, 1'b0);
        check_all("recover");

        // Push mismatch later; the first-fail index must not move.
        step(5'h04, 5'h04, 1'b1, 1'b0);
        check_all("push_mis");
        chk("push_mis.fv_const", 32'(fv_o), 32'd2);
        chk("push_mis.cnt_const", 32'(cnt_o), 32'd2);

        // Both mismatch kinds at once count as a single cycle.
        step(5'h01, 5'h11, 1'b0, 1'b1);
        check_all("both_mis");

        // Randomized traffic, mismatches injected about a quarter of the time.
        for (int i = 0; i < 200; i++) begin
            logic [DW-1:0] a, b;
            logic p, q;
            a = DW'($urandom);
            b = ($urandom_range(3, 0) == 0) ? DW'($urandom) : a;
            p = 1'($urandom);
            q = ($urandom_range(5, 0) == 0) ? ~p : p;
            step(a, b, p, q);
            check_all("random");
        end

        // 300 consecutive mismatches: the counter must saturate.
        for (int i = 0; i < 300; i++) step(5'h1F, 5'h00, 1'b1, 1'b1);
        check_all("saturate");
        chk("saturate.cnt_const", 32'(cnt_o), 32'd255);

        // Asynchronous reset mid-stream, away from any clock edge.
        #2 reset_L = 1'b0;
        model_reset();
        #1 check_all("mid_reset");
        @(negedge clk);
        reset_L = 1'b1;
        for (int i = 0; i < 4; i++) step(5'h0A, 5'h0A, 1'b0, 1'b0);
        check_all("post_reset");
        chk("post_reset.ok_const", 32'(ok_o), 32'd1);

`ifdef DEMUX_CHECKER_XCHECK_EN
        // Unknown on the structural push output is a push mismatch.
        step(5'h05, 5'h05, 1'b1, 1'bx);
        check_all("xcheck");
        chk("xcheck.fv_const", 32'(fv_o), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
